// File: rtl/dct_coeff_accum.sv
// rtl/dct_coeff_accum.sv - streaming MAC producing one saturated 2-D DCT coefficient per 8x8 block
module dct_coeff_accum #(
  parameter int PIX_W     = 8,
  parameter int COS_W     = 32,
  parameter int ACC_W     = 32,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PIX_W-1:0]        in_pixel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [2:0]              lut_n1,
  output logic [2:0]              lut_n2,
  input  logic signed [COS_W-1:0] lut_cos,
  output logic signed [OUT_W-1:0] out_coeff,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [PIX_W:0] LEVEL = (PIX_W+1)'(1) << (PIX_W-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t                    state;
  logic [5:0]                pixel_count;
  logic                      hs;

  logic signed [PIX_W:0]     pix_shifted;
  logic signed [ACC_W-1:0]   prod_next;
  logic signed [ACC_W-1:0]   prod;
  logic                      prod_valid;
  logic                      prod_first;
  logic                      prod_last;

  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sum_next;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [OUT_W-1:0]   coeff_next;

  // LUT index tracks the pixel being offered, so lut_cos lines up with in_pixel
  assign lut_n1 = pixel_count[5:3];
  assign lut_n2 = pixel_count[2:0];
  assign hs     = in_valid && in_ready;

  // Level-shift the pixel into a signed value and form the truncated product
  always_comb begin
    pix_shifted = $signed({1'b0, in_pixel} - LEVEL);
    prod_next   = pix_shifted * lut_cos;
  end

  // Block sequencing: accept 64 pixels, one drain cycle, then hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      pixel_count <= 6'd0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (hs) begin
            pixel_count <= pixel_count + 6'd1;
            if (pixel_count == 6'd63) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: register the product together with its block-position flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
    end else begin
      prod_valid <= hs;
      if (hs) begin
        prod       <= prod_next;
        prod_first <= (pixel_count == 6'd0);
        prod_last  <= (pixel_count == 6'd63);
      end
    end
  end

  // Running sum (first product restarts it), then scale and clamp to the output range
  always_comb begin
    sum_next = prod_first ? prod : acc + prod;
    shifted  = sum_next >>> FRAC_BITS;
    if (shifted > SAT_MAX) begin
      coeff_next = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      coeff_next = SAT_MIN[OUT_W-1:0];
    end else begin
      coeff_next = shifted[OUT_W-1:0];
    end
  end

  // Stage 2: accumulate products; the last one of a block commits the coefficient
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_coeff <= '0;
    end else if (prod_valid) begin
      acc <= sum_next;
      if (prod_last) begin
        out_coeff <= coeff_next;
      end
    end
  end

endmodule
